// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the control unit:
//     - opcode field width and opcode values (IR[31:27])
//     - FSM state encoding (5-bit binary)
//     - ctrl_sig_t: every strobe the control unit drives, bundled
// Optional feature macro used by importers: CTRL_MEMWAIT_EN
// -----------------------------------------------------------------------------
package ctrl_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [4:0] {
    RST    = 5'd0,
    FETCH0 = 5'd1,
    FETCH1 = 5'd2,
    FETCH2 = 5'd3,
    ALU3   = 5'd4,
    ALU4   = 5'd5,
    ALU5   = 5'd6,
    ADI3   = 5'd7,
    ADI4   = 5'd8,
    ADI5   = 5'd9,
    LS3    = 5'd10,
    LS4    = 5'd11,
    LS5    = 5'd12,
    LD6    = 5'd13,
    LD7    = 5'd14,
    ST6    = 5'd15,
    ST7    = 5'd16,
    BR3    = 5'd17,
    BR4    = 5'd18,
    BR5    = 5'd19,
    BR6    = 5'd20,
    MF3    = 5'd21,
    HALT   = 5'd22
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic ba_out;
    logic c_out;
    logic r_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic r_in;
    logic con_in;
    logic gra;
    logic grb;
    logic grc;
    logic inc_pc;
    logic read;
    logic write;
    logic run;
    logic illegal;
  } ctrl_sig_t;

endpackage

// File: rtl/ctrl_if.sv
// -----------------------------------------------------------------------------
// ctrl_if
//   Bundle between the control unit and the datapath.
//   master : control unit side (takes IR/CON/Stop, drives every strobe)
//   slave  : datapath side
//   Mem_ready exists only when CTRL_MEMWAIT_EN is defined.
// -----------------------------------------------------------------------------
interface ctrl_if;

  logic [31:0] IR;
  logic        CON;
  logic        Stop;
`ifdef CTRL_MEMWAIT_EN
  logic        Mem_ready;
`endif

  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, BAout, Cout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  logic Run, Illegal;

  modport master (
`ifdef CTRL_MEMWAIT_EN
    input  Mem_ready,
`endif
    input  IR, CON, Stop,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, BAout, Cout, Rout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin,
    output Gra, Grb, Grc, IncPC, Read, Write,
    output Run, Illegal
  );

  modport slave (
`ifdef CTRL_MEMWAIT_EN
    output Mem_ready,
`endif
    output IR, CON, Stop,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, BAout, Cout, Rout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin,
    input  Gra, Grb, Grc, IncPC, Read, Write,
    input  Run, Illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
//   Combinational opcode decoder used in FETCH2.
//   Ports:
//     opcode      in   IR[31:27]
//     entry_state out  first execute state (FETCH0 for nop/undefined, HALT for halt)
//     illegal     out  opcode is not defined
// -----------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output state_t         entry_state,
  output logic           illegal
);

  always_comb begin
    entry_state = FETCH0;
    illegal     = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: entry_state = ALU3;
      OP_ADDI:                       entry_state = ADI3;
      OP_LD, OP_ST:                  entry_state = LS3;
      OP_BR:                         entry_state = BR3;
      OP_MFHI, OP_MFLO:              entry_state = MF3;
      OP_NOP:                        entry_state = FETCH0;
      OP_HALT:                       entry_state = HALT;
      default: begin
        entry_state = FETCH0;
        illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Hard-wired Moore sequencer for the datapath: fetch (FETCH0-2), a
//   per-opcode execute sequence, then back to FETCH0.
//   Ports:
//     Clock    in   system clock, rising edge
//     Reset_n  in   asynchronous active-low reset (forces RST, all outputs 0)
//     bus      ctrl_if.master: IR, CON, Stop (+Mem_ready) in; strobes, Run,
//              Illegal out
//   Optional feature: CTRL_MEMWAIT_EN -- FETCH1, LD6 and ST7 hold until
//   Mem_ready=1; without it memory is single-cycle.
//
//   state  | meaning
//   RST    | in reset, everything idle
//   FETCH0 | PC -> MAR, PC+1 -> Z; Stop sampled here
//   FETCH1 | Z -> PC, memory read into MDR
//   FETCH2 | MDR -> IR, opcode decoded
//   ALU3-5 | reg-reg ALU op
//   ADI3-5 | reg-immediate add
//   LS3-5  | ld/st effective address -> MAR
//   LD6-7  | memory read, MDR -> Ra
//   ST6-7  | Ra -> MDR, memory write
//   BR3-6  | condition eval, PC+C, conditional PC load
//   MF3    | HI or LO -> Ra
//   HALT   | stopped until reset
// -----------------------------------------------------------------------------
module control_unit
  import ctrl_pkg::*;
(
  input  logic   Clock,
  input  logic   Reset_n,
  ctrl_if.master bus
);

  state_t         state_q, state_d;
  state_t         entry_state;
  logic           dec_illegal;
  logic           mem_ready;
  logic [OPW-1:0] opcode;
  ctrl_sig_t      sig;

  assign opcode = bus.IR[31:27];

`ifdef CTRL_MEMWAIT_EN
  assign mem_ready = bus.Mem_ready;
`else
  assign mem_ready = 1'b1;
`endif

  ctrl_decode u_decode (
    .opcode      (opcode),
    .entry_state (entry_state),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= RST;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:    state_d = FETCH0;
      FETCH0: state_d = bus.Stop ? HALT : FETCH1;
      FETCH1: state_d = mem_ready ? FETCH2 : FETCH1;
      FETCH2: state_d = entry_state;
      ALU3:   state_d = ALU4;
      ALU4:   state_d = ALU5;
      ALU5:   state_d = FETCH0;
      ADI3:   state_d = ADI4;
      ADI4:   state_d = ADI5;
      ADI5:   state_d = FETCH0;
      LS3:    state_d = LS4;
      LS4:    state_d = LS5;
      // ld and st share the address phase; IR still holds the opcode here
      LS5:    state_d = (opcode == OP_LD) ? LD6 : ST6;
      LD6:    state_d = mem_ready ? LD7 : LD6;
      LD7:    state_d = FETCH0;
      ST6:    state_d = ST7;
      ST7:    state_d = mem_ready ? FETCH0 : ST7;
      BR3:    state_d = BR4;
      BR4:    state_d = BR5;
      BR5:    state_d = BR6;
      BR6:    state_d = FETCH0;
      MF3:    state_d = FETCH0;
      HALT:   state_d = HALT;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    sig     = '0;
    sig.run = (state_q != RST) && (state_q != HALT);
    case (state_q)
      FETCH0: begin
        sig.pc_out = 1'b1; sig.mar_in = 1'b1; sig.inc_pc = 1'b1; sig.z_in = 1'b1;
      end
      FETCH1: begin
        sig.zlow_out = 1'b1; sig.pc_in = 1'b1; sig.read = 1'b1; sig.mdr_in = 1'b1;
      end
      FETCH2: begin
        sig.mdr_out = 1'b1; sig.ir_in = 1'b1;
        sig.illegal = dec_illegal;
      end
      ALU3, ADI3: begin
        sig.grb = 1'b1; sig.r_out = 1'b1; sig.y_in = 1'b1;
      end
      ALU4: begin
        sig.grc = 1'b1; sig.r_out = 1'b1; sig.z_in = 1'b1;
      end
      ADI4, LS4, BR5: begin
        sig.c_out = 1'b1; sig.z_in = 1'b1;
      end
      ALU5, ADI5: begin
        sig.zlow_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1;
      end
      LS3: begin
        sig.grb = 1'b1; sig.ba_out = 1'b1; sig.y_in = 1'b1;
      end
      LS5: begin
        sig.zlow_out = 1'b1; sig.mar_in = 1'b1;
      end
      LD6: begin
        sig.read = 1'b1; sig.mdr_in = 1'b1;
      end
      LD7: begin
        sig.mdr_out = 1'b1; sig.gra = 1'b1; sig.r_in = 1'b1;
      end
      ST6: begin
        sig.gra = 1'b1; sig.r_out = 1'b1; sig.mdr_in = 1'b1;
      end
      ST7: sig.write = 1'b1;
      BR3: begin
        sig.gra = 1'b1; sig.r_out = 1'b1; sig.con_in = 1'b1;
      end
      BR4: begin
        sig.pc_out = 1'b1; sig.y_in = 1'b1;
      end
      BR6: begin
        sig.zlow_out = 1'b1;
        sig.pc_in    = bus.CON;
      end
      MF3: begin
        // mfhi and mflo differ only in IR[27]
        sig.hi_out = ~opcode[0];
        sig.lo_out = opcode[0];
        sig.gra    = 1'b1;
        sig.r_in   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCout    = sig.pc_out;
  assign bus.Zlowout  = sig.zlow_out;
  assign bus.Zhighout = sig.zhigh_out;
  assign bus.MDRout   = sig.mdr_out;
  assign bus.HIout    = sig.hi_out;
  assign bus.LOout    = sig.lo_out;
  assign bus.BAout    = sig.ba_out;
  assign bus.Cout     = sig.c_out;
  assign bus.Rout     = sig.r_out;
  assign bus.PCin     = sig.pc_in;
  assign bus.MARin    = sig.mar_in;
  assign bus.MDRin    = sig.mdr_in;
  assign bus.IRin     = sig.ir_in;
  assign bus.Yin      = sig.y_in;
  assign bus.Zin      = sig.z_in;
  assign bus.HIin     = sig.hi_in;
  assign bus.LOin     = sig.lo_in;
  assign bus.Rin      = sig.r_in;
  assign bus.CONin    = sig.con_in;
  assign bus.Gra      = sig.gra;
  assign bus.Grb      = sig.grb;
  assign bus.Grc      = sig.grc;
  assign bus.IncPC    = sig.inc_pc;
  assign bus.Read     = sig.read;
  assign bus.Write    = sig.write;
  assign bus.Run      = sig.run;
  assign bus.Illegal  = sig.illegal;

endmodule
